jtag_debug_sysclk_bridge: RTL
=============================

JTAG_DEBUG_SYSCLK_BRIDGE -- requirements
Module: jtag_debug_sysclk_bridge

Interface
REQ-001 Parameter DR_W, default 38: width of the debug data register and of cmd_data.
REQ-002 Parameter IR_W, default 2: width of the instruction register; N_CH = 2**IR_W action channels.
REQ-003 Parameter DEPTH, default 4, power of two >= 2: number of command FIFO entries.
REQ-004 Parameter ACT_BIT, default DR_W-1: index of the sr bit that selects action versus no-action.
REQ-005 Port clk, input, 1: system clock; the block's only clock.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port vs_udr, input, 1: update-DR level from the TCK domain; asynchronous to clk.
REQ-008 Port vs_uir, input, 1: update-IR level from the TCK domain; asynchronous to clk.
REQ-009 Port ir_in, input, IR_W: instruction; stable while vs_udr or vs_uir is high.
REQ-010 Port sr, input, DR_W: shifted data; stable while vs_udr is high.
REQ-011 Port cmd_valid, output, 1: FIFO head is valid.
REQ-012 Port cmd_ready, input, 1: consumer accepts the head.
REQ-013 Port cmd_ir, output, IR_W: instruction of the head entry.
REQ-014 Port cmd_data, output, DR_W: data of the head entry (jdo equivalent).
REQ-015 Port take_action, output, N_CH: one-hot, one-cycle pulse on pop with the action bit set.
REQ-016 Port take_no_action, output, N_CH: one-hot, one-cycle pulse on pop with the action bit clear.
REQ-017 Port uir_pulse, output, 1: one-cycle pulse per update-IR event.
REQ-018 Port level, output, $clog2(DEPTH)+1: FIFO occupancy.
REQ-019 Port overflow, output, 1: sticky flag; set when an update is dropped.
REQ-020 Port ovf_clr, input, 1: clears overflow.

Function
REQ-021 vs_udr and vs_uir SHALL each pass through a 2-flop synchronizer and then a third flop; an event is detected as sync2 & ~sync3.
REQ-022 Latency: a udr event SHALL write the FIFO on the 3rd clk edge after the first edge that samples vs_udr high; cmd_valid is visible after that edge.
REQ-023 The FIFO write SHALL capture {ir_in, sr} on the event cycle.
REQ-024 Pop occurs when cmd_valid & cmd_ready; the FIFO is first-word fall-through, so cmd_ir and cmd_data show the head combinationally from storage.
REQ-025 On a pop, take_action[cmd_ir] SHALL pulse in the following cycle if cmd_data[ACT_BIT]=1; otherwise take_no_action[cmd_ir] pulses; all other bits stay 0.
REQ-026 Full with a udr event and no pop in the same cycle: the event is dropped, overflow is set, and FIFO contents are unchanged.
REQ-027 Full with a udr event and a pop in the same cycle: the write is accepted and level is unchanged.
REQ-028 Empty: cmd_ready is ignored, and no take_* pulse occurs.
REQ-029 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; level = writes - pops, saturating at 0 and DEPTH.
REQ-030 ovf_clr SHALL clear overflow; a simultaneous drop SHALL win, leaving overflow=1.
REQ-031 uir_pulse SHALL be high for exactly one clk per vs_uir rising level, 3 edges after sampling; it has no effect on the FIFO.
REQ-032 A level held high for many cycles SHALL produce exactly one event.

Reset
REQ-033 While reset is high, SHALL clear the synchronizer flops, pointers, level, and overflow; take_action, take_no_action, and uir_pulse are 0, and cmd_valid is 0.
REQ-034 Reset asserted mid-operation SHALL discard all queued commands; a vs_udr that is still high at reset release SHALL NOT generate an event until it goes low and high again.

Structure
REQ-035 A shared package jtag_dbg_pkg SHALL hold the default DR_W/IR_W constants and the cmd entry struct {ir, data}.
REQ-036 The synchronizer plus edge detect SHALL be one sub-module, dbg_sync_edge, instantiated twice.

Verification
REQ-037 Single udr, IR=2, sr[37]=1, data 0x2A_5A5A_5A5A, cmd_ready=1 -> cmd_valid at edge 3, take_action=4'b0100 for 1 cycle, cmd_data matches.
REQ-038 sr[37]=0, IR=1 -> take_no_action=4'b0010; take_action stays 0.
REQ-039 cmd_ready=0 with 5 udr events, DEPTH=4 -> level=4, overflow=1, and the 4 entries pop in order; ovf_clr -> overflow=0.
REQ-040 FIFO full, udr event coincident with a pop -> level stays 4 and the new entry is last.
REQ-041 vs_udr held high for 20 cycles -> exactly one write; with vs_uir toggling -> one uir_pulse per rise.
REQ-042 Reset for 1 cycle with 3 queued entries and vs_udr high -> level=0, no event until vs_udr falls and rises again.

Source files
------------

// File: rtl/jtag_dbg_pkg.sv
// Shared constants and command entry layout for the JTAG debug to system-clock bridge.
package jtag_dbg_pkg;

    localparam int DR_W_DEF = 38;
    localparam int IR_W_DEF = 2;

    typedef struct packed {
        logic [IR_W_DEF-1:0] ir;
        logic [DR_W_DEF-1:0] data;
    } cmd_entry_t;

endpackage

// File: rtl/dbg_sync_edge.sv
// Two-flop synchronizer plus a third flop for rising-edge detection of a TCK-domain level.
module dbg_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic evt
);

    logic sync_p0;
    logic sync_p1;
    logic sync_p2;
    logic live_p0;
    logic armed_p0;

    // A level already high when reset drops must go low once before it may fire.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0  <= 1'b0;
            sync_p1  <= 1'b0;
            sync_p2  <= 1'b0;
            live_p0  <= 1'b0;
            armed_p0 <= 1'b0;
        end else begin
            sync_p0  <= async_in;
            sync_p1  <= sync_p0;
            sync_p2  <= sync_p1;
            live_p0  <= 1'b1;
            armed_p0 <= armed_p0 | (live_p0 & ~sync_p0);
        end
    end

    assign evt = sync_p1 & ~sync_p2 & armed_p0;

endmodule

// File: rtl/jtag_debug_sysclk_bridge.sv
// Moves JTAG update-DR commands into the system clock domain through a small FWFT FIFO
// and turns each consumed command into a one-hot action / no-action pulse.
module jtag_debug_sysclk_bridge
    import jtag_dbg_pkg::*;
#(
    parameter int DR_W    = DR_W_DEF,
    parameter int IR_W    = IR_W_DEF,
    parameter int DEPTH   = 4,
    parameter int ACT_BIT = DR_W - 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   vs_udr,
    input  logic                   vs_uir,
    input  logic [IR_W-1:0]        ir_in,
    input  logic [DR_W-1:0]        sr,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [IR_W-1:0]        cmd_ir,
    output logic [DR_W-1:0]        cmd_data,
    output logic [2**IR_W-1:0]     take_action,
    output logic [2**IR_W-1:0]     take_no_action,
    output logic                   uir_pulse,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    input  logic                   ovf_clr
);

    localparam int N_CH  = 2**IR_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = IR_W + DR_W;

    logic udr_evt;
    logic uir_evt;

    dbg_sync_edge u_udr_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (vs_udr),
        .evt      (udr_evt)
    );

    dbg_sync_edge u_uir_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (vs_uir),
        .evt      (uir_evt)
    );

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] lvl;
    logic [ENT_W-1:0] head;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
    assign cmd_valid = ~reset & (lvl != '0);
    assign full      = (lvl == LVL_W'(DEPTH));
    assign pop       = cmd_valid & cmd_ready;
    assign push      = udr_evt & (~full | pop);
    assign drop      = udr_evt & full & ~pop;
    assign head      = mem[rd_ptr];
    assign cmd_ir    = head[ENT_W-1 -: IR_W];
    assign cmd_data  = head[DR_W-1:0];
    assign level     = lvl;

    function automatic logic [N_CH-1:0] onehot(input logic [IR_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    // Storage carries data only and is never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {ir_in, sr};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            lvl      <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   lvl <= lvl + LVL_W'(1);
                2'b01:   lvl <= lvl - LVL_W'(1);
                default: lvl <= lvl;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Pulse stage: one cycle after the pop that consumed the head.
    always_ff @(posedge clk) begin
        if (reset) begin
            take_action    <= '0;
            take_no_action <= '0;
            uir_pulse      <= 1'b0;
        end else begin
            take_action    <= '0;
            take_no_action <= '0;
            if (pop) begin
                if (cmd_data[ACT_BIT]) begin
                    take_action <= onehot(cmd_ir);
                end else begin
                    take_no_action <= onehot(cmd_ir);
                end
            end
            uir_pulse <= uir_evt;
        end
    end

endmodule
